// File: rtl/spi_master.sv
// SPI-style frame master: 10-bit command out on MOSI, optional 8-bit read-back on MISO.
// Define SPI_MASTER_SEQ_CHECK_EN to reject rd-data frames not preceded by an rd-addr frame.
module spi_master #(
  parameter int unsigned TURNAROUND = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [9:0] cmd_word,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       err,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEAD    = 3'd1,
    SHIFT   = 3'd2,
    TURN    = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [3:0] TURN_LAST = 4'(TURNAROUND - 1);

  state_t     state_q, state_d;
  logic [9:0] sh_q, sh_d;
  logic [1:0] op_q, op_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] cap_q, cap_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       ss_n_q, ss_n_d;
  logic       mosi_q, mosi_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       rv_q, rv_d;
  logic       reject;

`ifdef SPI_MASTER_SEQ_CHECK_EN
  logic       flag_q, flag_d;
  logic       err_q, err_d;
  assign reject = (cmd_word[9:8] == 2'b11) && !flag_q;
`else
  assign reject = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    cap_d     = cap_q;
    rd_data_d = rd_data_q;
    mosi_d    = 1'b0;
`ifdef SPI_MASTER_SEQ_CHECK_EN
    flag_d    = flag_q;
    err_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (reject) begin
`ifdef SPI_MASTER_SEQ_CHECK_EN
            err_d = 1'b1;
`endif
          end else begin
            sh_d    = cmd_word;
            op_d    = cmd_word[9:8];
            state_d = LEAD;
          end
        end
      end
      LEAD: begin
        // Present the first command bit so it appears in the first SHIFT cycle.
        mosi_d  = sh_q[9];
        sh_d    = {sh_q[8:0], 1'b0};
        cnt_d   = 4'd0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt_q == 4'd9) begin
          cnt_d   = 4'd0;
          state_d = (op_q == 2'b11) ? TURN : DONE;
        end else begin
          mosi_d = sh_q[9];
          sh_d   = {sh_q[8:0], 1'b0};
          cnt_d  = cnt_q + 4'd1;
        end
      end
      TURN: begin
        if (cnt_q == TURN_LAST) begin
          cnt_d   = 4'd0;
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      CAPTURE: begin
        cap_d = {cap_q[6:0], MISO};
        if (cnt_q == 4'd7) begin
          rd_data_d = {cap_q[6:0], MISO};
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef SPI_MASTER_SEQ_CHECK_EN
        if (op_q == 2'b10) flag_d = 1'b1;
        else if (op_q == 2'b11) flag_d = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered images of the upcoming state.
    ss_n_d = (state_d == IDLE) || (state_d == DONE);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    rv_d   = (state_d == DONE) && (op_d == 2'b11);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      op_q      <= '0;
      cnt_q     <= '0;
      cap_q     <= '0;
      rd_data_q <= '0;
      ss_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      cap_q     <= cap_d;
      rd_data_q <= rd_data_d;
      ss_n_q    <= ss_n_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rv_q      <= rv_d;
    end
  end

`ifdef SPI_MASTER_SEQ_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      err_q  <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rv_q;
  assign SS_n     = ss_n_q;
  assign MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: stimulus queues expected frames, a negedge monitor checks them.
module tb_spi_master;

  localparam int T = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [9:0] cmd_word;
  logic       busy, done, rd_valid, err, SS_n, MOSI, MISO;
  logic [7:0] rd_data;

  spi_master #(.TURNAROUND(T)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd_word(cmd_word),
    .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
    .err(err), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] mosi;
    int          ss_len;
    int          lat;
    int          start_cyc;
    logic        rv;
    logic [7:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   err_count = 0;
  int   done_count = 0;
  logic [10:0] cap_bits = '0;
  int   cap_len = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  // Monitor: compares every completed frame against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err) err_count++;
      if (rd_valid && !done) chk("rd_valid_without_done", 32'(rd_valid), 32'd0);
      if (done) begin
        done_count++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("frame done cmd_bits=%b ss_len=%0d rd_valid=%0b rd_data=%02h", cap_bits, cap_len, rd_valid, rd_data);
          chk("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
          chk("mosi_bits", 32'(cap_bits), 32'(e.mosi));
          chk("ss_len", 32'(cap_len), 32'(e.ss_len));
          chk("rd_valid", 32'(rd_valid), 32'(e.rv));
          chk("rd_data", 32'(rd_data), 32'(e.rd));
        end
        cap_bits = '0;
        cap_len  = 0;
      end else if (SS_n) begin
        cap_bits = '0;
        cap_len  = 0;
      end else begin
        if (cap_len < 11) cap_bits = {cap_bits[9:0], MOSI};
        cap_len++;
      end
    end
  end

  // Issues one frame starting at the current negedge; returns at the negedge after done.
  task automatic run_frame(input logic [9:0] cmd, input logic [7:0] miso_byte,
                           input logic [7:0] exp_rd, input bit inject);
    exp_t e;
    bit   is_rd;
    int   lat;
    is_rd       = (cmd[9:8] == 2'b11);
    lat         = is_rd ? 20 + T : 12;
    e.mosi      = {1'b0, cmd};
    e.ss_len    = is_rd ? 19 + T : 11;
    e.lat       = lat;
    e.start_cyc = cyc;
    e.rv        = is_rd;
    e.rd        = exp_rd;
    sb.push_back(e);
    start    = 1'b1;
    cmd_word = cmd;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (is_rd && k >= 12 + T && k <= 19 + T) MISO = miso_byte[19 + T - k];
      else MISO = 1'b0;
      if (inject && k == 4) begin
        start    = 1'b1;
        cmd_word = ~cmd;
      end
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    chk("rst_SS_n", 32'(SS_n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'h00);
    chk("rst_MOSI", 32'(MOSI), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
  endtask

  initial begin
    int dc;
    rst_n = 1'b0; start = 1'b0; cmd_word = '0; MISO = 1'b0;
    #12;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_frame(10'b00_1010_0101, 8'h00, 8'h00, 1'b0);
    run_frame(10'b10_0001_0000, 8'h00, 8'h00, 1'b0);
    run_frame(10'b11_0000_0000, 8'h3C, 8'h3C, 1'b0);
    run_frame(10'b01_1111_0000, 8'h00, 8'h3C, 1'b0);
    run_frame(10'b10_1000_0001, 8'h00, 8'h3C, 1'b0);
    run_frame(10'b11_1111_1111, 8'h81, 8'h81, 1'b0);
    run_frame(10'b01_0110_0110, 8'h00, 8'h81, 1'b1);
    run_frame(10'b10_0000_0000, 8'h00, 8'h81, 1'b0);
    run_frame(10'b11_0000_0001, 8'h5A, 8'h5A, 1'b0);

    // Abort a frame at cycle 6 with an asynchronous reset.
    dc = done_count;
    start = 1'b1; cmd_word = 10'b00_0000_0001;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("busy_before_abort", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    chk("abort_no_done", 32'(done_count), 32'(dc));

`ifdef SPI_MASTER_SEQ_CHECK_EN
    start = 1'b1; cmd_word = 10'b11_0000_0000;
    @(negedge clk);
    start = 1'b0;
    chk("seq_err_pulse", 32'(err), 32'd1);
    chk("seq_SS_n", 32'(SS_n), 32'd1);
    chk("seq_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("seq_err_one_cycle", 32'(err), 32'd0);
    chk("seq_SS_n_after", 32'(SS_n), 32'd1);
`else
    run_frame(10'b11_0000_0000, 8'hC3, 8'hC3, 1'b0);
`endif
    run_frame(10'b00_0101_1010, 8'h00, 8'hC3 & {8{1'b0}}
`ifndef SPI_MASTER_SEQ_CHECK_EN
              | 8'hC3
`endif
              , 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
`ifdef SPI_MASTER_SEQ_CHECK_EN
    chk("err_pulse_count", 32'(err_count), 32'd1);
`else
    chk("err_pulse_count", 32'(err_count), 32'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter TURNAROUND, default 2, gives the idle clk cycles between the last command bit and the first MISO sample on read-data frames (range 1..15).
REQ-002 clk  input  1  system clock; all SPI signals are launched and sampled on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle request to issue one frame; sampled only in IDLE.
REQ-005 cmd_word  input  10  frame content: [9:8] opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] address/data; captured on accepted start.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 done  output  1  one-cycle pulse at frame end.
REQ-008 rd_data  output  8  byte captured from MISO on the last rd-data frame.
REQ-009 rd_valid  output  1  one-cycle pulse, coincident with done, on rd-data frames only.
REQ-010 err  output  1  one-cycle pulse on a rejected request (see REQ-026).
REQ-011 SS_n  output  1  slave select, active-low.
REQ-012 MOSI  output  1  serial command out, MSB first.
REQ-013 MISO  input  1  serial read data in, MSB first.

Function
REQ-014 FSM states: IDLE, LEAD, SHIFT, TURN, CAPTURE, DONE; all outputs driven from registers.
REQ-015 IDLE: SS_n=1, MOSI=0; start=1 latches cmd_word into a 10-bit shift register, next state LEAD.
REQ-016 LEAD: one cycle, SS_n=0, MOSI=0; next state SHIFT.
REQ-017 SHIFT: 10 cycles, SS_n=0, MOSI = cmd_word[9] down to cmd_word[0], one bit per cycle.
REQ-018 After SHIFT: opcode 11 goes to TURN; all other opcodes go to DONE.
REQ-019 TURN: TURNAROUND cycles, SS_n=0, MOSI=0; next state CAPTURE.
REQ-020 CAPTURE: 8 cycles, SS_n=0; MISO is sampled each cycle and shifted in MSB first; next state DONE.
REQ-021 DONE: one cycle, SS_n=1, done=1, and rd_valid=1 if opcode 11; rd_data updates in this cycle and holds until the next rd-data DONE; next state IDLE.
REQ-022 Latency for start accepted at cycle 0: non-read frames give done at cycle 12; rd-data frames give done at cycle 20+TURNAROUND. The next start is accepted no earlier than cycle done+1.
REQ-023 A start pulse while busy=1 is ignored; no queuing, and cmd_word is not re-sampled.
REQ-024 SS_n stays high for at least 1 cycle (DONE) between consecutive frames.

Reset
REQ-025 When rst_n=0, in any state, the block immediately enters IDLE: SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, err=0, rd_data=8'h00, and the sequence flag is cleared. An aborted frame produces no done.

Configuration
REQ-026 Macro SPI_MASTER_SEQ_CHECK_EN, when defined:
- An internal flag is set at DONE of an opcode-10 frame and cleared at DONE of an opcode-11 frame.
- A start with opcode 11 while the flag is clear is rejected: err pulses for 1 cycle, the state stays IDLE, and no SS_n activity occurs.
REQ-027 When SPI_MASTER_SEQ_CHECK_EN is undefined, all opcodes are issued, err is tied to 0, and no flag logic exists.

Verification
REQ-028 Write frame: start with cmd_word=10'b00_1010_0101 -> SS_n low cycles 1-11, MOSI 0,0,0,1,0,1,0,0,1,0,1 over cycles 1-11, done at cycle 12, rd_valid stays 0.
REQ-029 Read pair, TURNAROUND=2: cmd 10'b10_0001_0000, then cmd 10'b11_0000_0000 with MISO driving 0x3C MSB first in cycles 14-21 -> rd_data=8'h3C, rd_valid and done at cycle 22.
REQ-030 Start asserted during SHIFT with a different cmd_word -> ignored; the MOSI sequence is unchanged and only one done occurs.
REQ-031 rst_n asserted at cycle 6 of a frame -> SS_n=1 and busy=0 asynchronously; no done; the next start after release runs a normal frame.
REQ-032 With SPI_MASTER_SEQ_CHECK_EN defined, opcode 11 issued after reset with no prior opcode 10 -> err=1 for 1 cycle, SS_n stays 1, busy stays 0; without the macro -> the frame runs and err stays 0.
